// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_pkg
// Description : Shared types and constants for the OBI data-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package obi_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int OBI_ADDR_W  = 32;
    localparam int OBI_DATA_W  = 32;

    // Master ID: 0 = LSU, 1 = secondary master
    typedef logic mid_t;

    typedef struct packed {
        logic [OBI_ADDR_W-1:0]   addr;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_DATA_W-1:0]   wdata;
    } obi_req_t;

endpackage
`default_nettype wire

// File: rtl/obi_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : obi_id_fifo
// Description : In-order FIFO of granted master IDs used to steer responses.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_id_fifo
    import obi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  mid_t                       din,
    output mid_t                       head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    mid_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/obi_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : obi_data_arbiter
// Description : Round-robin arbiter sharing one OBI data port between the LSU
//               (m0) and a secondary master (m1), with in-order response steering.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_data_arbiter
    import obi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_MASTERS-1:0]             m_req_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0]      m_addr_i,
    input  logic [NUM_MASTERS-1:0]             m_we_i,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]  m_be_i,
    input  logic [NUM_MASTERS*DATA_W-1:0]      m_wdata_i,
    output logic [NUM_MASTERS-1:0]             m_gnt_o,
    output logic [NUM_MASTERS-1:0]             m_rvalid_o,
    output logic [DATA_W-1:0]                  m_rdata_o,
    output logic                               data_req_o,
    output logic [ADDR_W-1:0]                  data_addr_o,
    output logic                               data_we_o,
    output logic [DATA_W/8-1:0]                data_be_o,
    output logic [DATA_W-1:0]                  data_wdata_o,
    input  logic                               data_gnt_i,
    input  logic                               data_rvalid_i,
    input  logic [DATA_W-1:0]                  data_rdata_i,
    output logic                               busy_o,
    output logic                               spurious_o
);

    localparam int c_BE_W  = DATA_W / 8;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    mid_t               r_rr_ptr;
    logic               r_lock;
    mid_t               r_locked_id;

    mid_t               w_sel;
    logic               w_req;
    logic               w_hs;
    logic               w_pop;
    mid_t               w_head;
    logic [c_CNT_W-1:0] w_count;
    logic               w_full;
    logic               w_empty;

    // A stalled request keeps its master selected until granted
    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_locked_id;
        end else if (&m_req_i) begin
            w_sel = r_rr_ptr;
        end else if (m_req_i[1]) begin
            w_sel = 1'b1;
        end
    end

    // Full is not relieved by a same-cycle pop: keeps rvalid off the req path
    assign w_req = m_req_i[w_sel] & ~w_full & ~rst;
    assign w_hs  = w_req & data_gnt_i;
    assign w_pop = data_rvalid_i & ~w_empty & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= 1'b0;
            r_lock      <= 1'b0;
            r_locked_id <= 1'b0;
        end else if (w_hs) begin
            r_rr_ptr <= ~w_sel;
            r_lock   <= 1'b0;
        end else if (w_req) begin
            r_lock      <= 1'b1;
            r_locked_id <= w_sel;
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_hs),
        .pop   (w_pop),
        .din   (w_sel),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign data_req_o   = w_req;
    assign data_addr_o  = rst ? '0 : (w_sel ? m_addr_i[2*ADDR_W-1:ADDR_W] : m_addr_i[ADDR_W-1:0]);
    assign data_we_o    = ~rst & m_we_i[w_sel];
    assign data_be_o    = rst ? '0 : (w_sel ? m_be_i[2*c_BE_W-1:c_BE_W] : m_be_i[c_BE_W-1:0]);
    assign data_wdata_o = rst ? '0 : (w_sel ? m_wdata_i[2*DATA_W-1:DATA_W] : m_wdata_i[DATA_W-1:0]);

    assign m_gnt_o    = {w_hs & w_sel, w_hs & ~w_sel};
    assign m_rvalid_o = {w_pop & w_head, w_pop & ~w_head};
    assign m_rdata_o  = rst ? '0 : data_rdata_i;

    assign busy_o     = ~rst & (w_count != '0);
    assign spurious_o = ~rst & data_rvalid_i & w_empty;

endmodule
`default_nettype wire

// File: tb/tb_obi_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_data_arbiter
// Description : Directed, table-driven self-checking bench for obi_data_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_data_arbiter;

    localparam logic [31:0] c_A0  = 32'h0000_0100;
    localparam logic [31:0] c_A1  = 32'h0000_0200;
    localparam logic [31:0] c_W0  = 32'h1111_0000;
    localparam logic [31:0] c_W1  = 32'h2222_0001;
    localparam logic [3:0]  c_BE0 = 4'hF;
    localparam logic [3:0]  c_BE1 = 4'h3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req_i;
    logic [63:0] m_addr_i;
    logic [1:0]  m_we_i;
    logic [7:0]  m_be_i;
    logic [63:0] m_wdata_i;
    logic [1:0]  m_gnt_o;
    logic [1:0]  m_rvalid_o;
    logic [31:0] m_rdata_o;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        busy_o;
    logic        spurious_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic        e_req;
        logic [31:0] e_addr;
        logic [1:0]  e_rv;
        logic        e_busy;
        logic        e_spur;
    } vec_t;

    obi_data_arbiter #(
        .MAX_OUTSTANDING (2),
        .ADDR_W          (32),
        .DATA_W          (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m_req_i       (m_req_i),
        .m_addr_i      (m_addr_i),
        .m_we_i        (m_we_i),
        .m_be_i        (m_be_i),
        .m_wdata_i     (m_wdata_i),
        .m_gnt_o       (m_gnt_o),
        .m_rvalid_o    (m_rvalid_o),
        .m_rdata_o     (m_rdata_o),
        .data_req_o    (data_req_o),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .busy_o        (busy_o),
        .spurious_o    (spurious_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [1:0] req, logic gnt, logic rv, logic [31:0] rdata,
                                logic [1:0] e_gnt, logic e_req, logic [31:0] e_addr,
                                logic [1:0] e_rv, logic e_busy, logic e_spur);
        vec_t v;
        v.req = req;     v.gnt = gnt;       v.rv = rv;         v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_req = e_req;   v.e_addr = e_addr;
        v.e_rv = e_rv;   v.e_busy = e_busy; v.e_spur = e_spur;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are driven 1ns after the edge; outputs sampled at mid-cycle
    task automatic run_vec(string tag, vec_t v);
        m_req_i       = v.req;
        data_gnt_i    = v.gnt;
        data_rvalid_i = v.rv;
        data_rdata_i  = v.rdata;
        #4;
        check({tag, ".gnt"},    32'(m_gnt_o),    32'(v.e_gnt));
        check({tag, ".req"},    32'(data_req_o), 32'(v.e_req));
        check({tag, ".addr"},   data_addr_o,     v.e_addr);
        check({tag, ".wdata"},  data_wdata_o,    (v.e_addr == c_A1) ? c_W1 : c_W0);
        check({tag, ".we"},     32'(data_we_o),  (v.e_addr == c_A1) ? 32'd1 : 32'd0);
        check({tag, ".be"},     32'(data_be_o),  32'((v.e_addr == c_A1) ? c_BE1 : c_BE0));
        check({tag, ".rvalid"}, 32'(m_rvalid_o), 32'(v.e_rv));
        check({tag, ".rdata"},  m_rdata_o,       v.rdata);
        check({tag, ".busy"},   32'(busy_o),     32'(v.e_busy));
        check({tag, ".spur"},   32'(spurious_o), 32'(v.e_spur));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle(string tag);
        rst           = 1'b1;
        m_req_i       = 2'b11;
        data_gnt_i    = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFF_FFFF;
        #4;
        check({tag, ".gnt"},    32'(m_gnt_o),    32'd0);
        check({tag, ".rvalid"}, 32'(m_rvalid_o), 32'd0);
        check({tag, ".req"},    32'(data_req_o), 32'd0);
        check({tag, ".addr"},   data_addr_o,     32'd0);
        check({tag, ".wdata"},  data_wdata_o,    32'd0);
        check({tag, ".rdata"},  m_rdata_o,       32'd0);
        check({tag, ".busy"},   32'(busy_o),     32'd0);
        check({tag, ".spur"},   32'(spurious_o), 32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        m_req_i       = 2'b00;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
    endtask

    vec_t vecs[18];

    initial begin
        m_addr_i  = {c_A1, c_A0};
        m_wdata_i = {c_W1, c_W0};
        m_be_i    = {c_BE1, c_BE0};
        m_we_i    = 2'b10;

        // single read, round-robin alternation, full blocking, spurious response
        vecs[0]  = mk(2'b01, 1, 0, 32'h0,         2'b01, 1, c_A0, 2'b00, 0, 0);
        vecs[1]  = mk(2'b00, 0, 0, 32'h0,         2'b00, 0, c_A0, 2'b00, 1, 0);
        vecs[2]  = mk(2'b00, 0, 1, 32'hDEADBEEF,  2'b00, 0, c_A0, 2'b01, 1, 0);
        vecs[3]  = mk(2'b00, 0, 0, 32'h0,         2'b00, 0, c_A0, 2'b00, 0, 0);
        vecs[4]  = mk(2'b11, 1, 0, 32'h0,         2'b10, 1, c_A1, 2'b00, 0, 0);
        vecs[5]  = mk(2'b11, 1, 1, 32'h0000_0005, 2'b01, 1, c_A0, 2'b10, 1, 0);
        vecs[6]  = mk(2'b11, 1, 1, 32'h0000_0006, 2'b10, 1, c_A1, 2'b01, 1, 0);
        vecs[7]  = mk(2'b11, 1, 1, 32'h0000_0007, 2'b01, 1, c_A0, 2'b10, 1, 0);
        vecs[8]  = mk(2'b00, 0, 1, 32'h0000_0008, 2'b00, 0, c_A0, 2'b01, 1, 0);
        vecs[9]  = mk(2'b01, 1, 0, 32'h0,         2'b01, 1, c_A0, 2'b00, 0, 0);
        vecs[10] = mk(2'b10, 1, 0, 32'h0,         2'b10, 1, c_A1, 2'b00, 1, 0);
        vecs[11] = mk(2'b01, 1, 0, 32'h0,         2'b00, 0, c_A0, 2'b00, 1, 0);
        vecs[12] = mk(2'b01, 1, 1, 32'h0000_000C, 2'b00, 0, c_A0, 2'b01, 1, 0);
        vecs[13] = mk(2'b01, 1, 1, 32'h0000_000D, 2'b01, 1, c_A0, 2'b10, 1, 0);
        vecs[14] = mk(2'b00, 0, 1, 32'h0000_000E, 2'b00, 0, c_A0, 2'b01, 1, 0);
        vecs[15] = mk(2'b00, 0, 0, 32'h0,         2'b00, 0, c_A0, 2'b00, 0, 0);
        vecs[16] = mk(2'b00, 0, 1, 32'hBAD0_0010, 2'b00, 0, c_A0, 2'b00, 0, 1);
        vecs[17] = mk(2'b00, 0, 0, 32'h0,         2'b00, 0, c_A0, 2'b00, 0, 0);

        reset_cycle("rst0");
        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // lock: with rr favouring m1, a stalled m0 request keeps the port
        reset_cycle("rst1");
        run_vec("lock0", mk(2'b01, 1, 0, 32'h0, 2'b01, 1, c_A0, 2'b00, 0, 0));
        run_vec("lock1", mk(2'b01, 0, 1, 32'h1, 2'b00, 1, c_A0, 2'b01, 1, 0));
        run_vec("lock2", mk(2'b11, 0, 0, 32'h0, 2'b00, 1, c_A0, 2'b00, 0, 0));
        run_vec("lock3", mk(2'b11, 0, 0, 32'h0, 2'b00, 1, c_A0, 2'b00, 0, 0));
        run_vec("lock4", mk(2'b11, 1, 0, 32'h0, 2'b01, 1, c_A0, 2'b00, 0, 0));
        run_vec("lock5", mk(2'b10, 1, 0, 32'h0, 2'b10, 1, c_A1, 2'b00, 1, 0));
        run_vec("lock6", mk(2'b00, 0, 1, 32'h2, 2'b00, 0, c_A0, 2'b01, 1, 0));
        run_vec("lock7", mk(2'b00, 0, 1, 32'h3, 2'b00, 0, c_A0, 2'b10, 1, 0));

        // push+pop at count 1 across repeated pointer wraps
        reset_cycle("rst2");
        run_vec("wrap0", mk(2'b01, 1, 0, 32'h0, 2'b01, 1, c_A0, 2'b00, 0, 0));
        for (int i = 1; i <= 10; i++) begin
            logic [1:0] cur;
            logic [1:0] prv;
            cur = (i % 2 == 1) ? 2'b10 : 2'b01;
            prv = (i % 2 == 1) ? 2'b01 : 2'b10;
            run_vec($sformatf("wrap%0d", i),
                    mk(cur, 1, 1, 32'h100 + 32'(i), cur, 1, (cur == 2'b10) ? c_A1 : c_A0, prv, 1, 0));
        end
        run_vec("wrapd", mk(2'b00, 0, 1, 32'h77, 2'b00, 0, c_A0, 2'b01, 1, 0));
        run_vec("wrape", mk(2'b00, 0, 0, 32'h0,  2'b00, 0, c_A0, 2'b00, 0, 0));

        // reset with one outstanding: the late response is dropped as spurious
        run_vec("sp0", mk(2'b10, 1, 0, 32'h0, 2'b10, 1, c_A1, 2'b00, 0, 0));
        reset_cycle("rst3");
        run_vec("sp1", mk(2'b00, 0, 1, 32'hCAFE_0001, 2'b00, 0, c_A0, 2'b00, 0, 1));
        run_vec("sp2", mk(2'b00, 0, 0, 32'h0,         2'b00, 0, c_A0, 2'b00, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
